execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline.
- Combines three parts: the DEC/EX pipeline register (DEC_ALU), the forwarding-aware ALU, and the EX/MEM pipeline register (ALU_MEM).
- Takes decoded operands and control from decode/register file. Supplies the data-memory stage and the forwarding unit. Receives forwarding selects and MEM/WB write-back data from outside.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- OP_W, 5, ALU control width.
- DCC_W, 3, data-cache control width.

Ports:
- clk  in  1  pipeline clock.
- resetIn  in  1  asynchronous active-low reset.
- flush  in  1  bubble DEC/EX at next edge.
- dataReg1  in  DATA_W  rs1 value from register file.
- dataReg2  in  DATA_W  rs2 value from register file.
- dataS1AddrIn  in  REG_AW  rs1 address.
- dataS2AddrIn  in  REG_AW  rs2 address.
- writeBackAddrIn  in  REG_AW  rd address.
- ALUop  in  OP_W  ALU control from control unit.
- immValueIn  in  DATA_W  sign-extended immediate.
- dataCacheControlIn  in  DCC_W  memory op control (0 = none).
- writeEnableReg  in  1  rd write enable.
- select1  in  2  forward select, operand A.
- select2  in  2  forward select, operand B/store data.
- regDataFromMEM_WB  in  DATA_W  write-back data from MEM/WB.
- dataS1AddrOut  out  REG_AW  registered rs1 address, to forwarding unit.
- dataS2AddrOut  out  REG_AW  registered rs2 address, to forwarding unit.
- aluResult  out  DATA_W  combinational ALU result (debug/monitor).
- dataOut  out  DATA_W  registered ALU result (memory address / write-back value).
- dataRs2Out  out  DATA_W  registered store data.
- dataCacheControlOut  out  DCC_W  registered memory control.
- writeEnableOut  out  1  registered rd write enable.
- writeBackAddrOut  out  REG_AW  registered rd address.

Behaviour:
- Reset: resetIn low clears every DEC/EX and EX/MEM register to 0 immediately, independent of clk. All registered outputs read 0 while resetIn is low.
- DEC/EX register (posedge clk) captures: dataReg1/2, the three addresses, ALUop, immValueIn, dataCacheControlIn, writeEnableReg.
- flush high at an edge: DEC/EX loads writeEnable=0, dataCacheControl=0, ALUop=0. Other DEC/EX fields are don't-care.
- Forward mux, operand A (same rule for B and store data using select2 and rs2):
  - 0 = DEC/EX rs1 value.
  - 1 = EX/MEM dataOut.
  - 2 = regDataFromMEM_WB.
  - 3 = treated as 0 (register value).
- ALU operand B: the forwarded rs2 when ALUop[4]=0; the registered immediate when ALUop[4]=1.
- ALU function on ALUop[3:0]:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed, 1/0), 4 SLTU.
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 PASS_B (LUI).
  - 11–15 result 0.
- Arithmetic wraps modulo 2^32. Shift amount is B[4:0]. SRA replicates bit 31.
- ALU is purely combinational; aluResult reflects the current DEC/EX contents and selects.
- EX/MEM register (posedge clk) captures:
  - aluResult → dataOut.
  - Forwarded rs2 (not raw rs2) → dataRs2Out.
  - dataCacheControl, writeEnable, writeBackAddr passed through from DEC/EX.
- Latency: inputs sampled at edge N appear on the EX/MEM outputs after edge N+1.
- One instruction per cycle. No stall input; the upstream pipeline is always enabled.
- Back-to-back dependency: selects computed from dataS*AddrOut pick up the EX/MEM result in the same cycle. No bubble is needed for ALU→ALU dependencies.
- resetIn asserted mid-stream discards both in-flight instructions. Release of resetIn is synchronised by the system.

Test Plan:
- Reset: hold resetIn=0 and toggle clk → all registered outputs 0. Release → outputs stay 0 until an instruction is captured.
- ADDI, forwarding and write-back path:
  - Stimulus: dataReg1=5, imm=7, ALUop=5'b10000, writeEnableReg=1, rd=17, select1=0.
  - Response: after two edges dataOut=12, writeEnableOut=1, writeBackAddrOut=17.
- EX/MEM forwarding: ADD x1=3+4 followed by SUB x2=x1-1 with select1=1 → second dataOut=6.
- MEM/WB forwarding and store data:
  - Stimulus: select2=2, regDataFromMEM_WB=0xDEADBEEF, dataCacheControlIn=store code.
  - Response: dataRs2Out=0xDEADBEEF.
- Shifts and compares, with A=0x80000000, B=4:
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - SLT(A, 1) → 1.
  - SLTU(A, 1) → 0.
- Flush and asynchronous reset:
  - flush during a valid store → writeEnableOut=0 and dataCacheControlOut=0 one edge later.
  - Asserting resetIn between edges → outputs clear without a clock edge.

Source files
------------

// File: rtl/execute_stage_if.sv
// Signal bundle between decode/forwarding logic and the execute stage.
// The stage uses the slave side; the upstream driver uses the master side.
interface execute_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 5,
    parameter int DCC_W  = 3
);
    logic              flush;
    logic [DATA_W-1:0] dataReg1;
    logic [DATA_W-1:0] dataReg2;
    logic [REG_AW-1:0] dataS1AddrIn;
    logic [REG_AW-1:0] dataS2AddrIn;
    logic [REG_AW-1:0] writeBackAddrIn;
    logic [OP_W-1:0]   ALUop;
    logic [DATA_W-1:0] immValueIn;
    logic [DCC_W-1:0]  dataCacheControlIn;
    logic              writeEnableReg;
    logic [1:0]        select1;
    logic [1:0]        select2;
    logic [DATA_W-1:0] regDataFromMEM_WB;

    logic [REG_AW-1:0] dataS1AddrOut;
    logic [REG_AW-1:0] dataS2AddrOut;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] dataOut;
    logic [DATA_W-1:0] dataRs2Out;
    logic [DCC_W-1:0]  dataCacheControlOut;
    logic              writeEnableOut;
    logic [REG_AW-1:0] writeBackAddrOut;

    modport master (
        output flush, dataReg1, dataReg2, dataS1AddrIn, dataS2AddrIn,
               writeBackAddrIn, ALUop, immValueIn, dataCacheControlIn,
               writeEnableReg, select1, select2, regDataFromMEM_WB,
        input  dataS1AddrOut, dataS2AddrOut, aluResult, dataOut, dataRs2Out,
               dataCacheControlOut, writeEnableOut, writeBackAddrOut
    );

    modport slave (
        input  flush, dataReg1, dataReg2, dataS1AddrIn, dataS2AddrIn,
               writeBackAddrIn, ALUop, immValueIn, dataCacheControlIn,
               writeEnableReg, select1, select2, regDataFromMEM_WB,
        output dataS1AddrOut, dataS2AddrOut, aluResult, dataOut, dataRs2Out,
               dataCacheControlOut, writeEnableOut, writeBackAddrOut
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: DEC/EX register, forwarding ALU, EX/MEM register.
// No valid/ready: one instruction enters per clock; flush turns the entering slot into a bubble.
module execute_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 5,
    parameter int DCC_W  = 3
) (
    input logic             clk,
    input logic             resetIn,
    execute_stage_if.slave  bus
);
    // DEC/EX register
    logic [DATA_W-1:0] rs1_q, rs2_q, imm_q;
    logic [REG_AW-1:0] s1_addr_q, s2_addr_q, rd_q;
    logic [OP_W-1:0]   aluop_q, aluop_d;
    logic [DCC_W-1:0]  dcc_q, dcc_d;
    logic              we_q, we_d;

    // EX/MEM register
    logic [DATA_W-1:0] data_out_q, rs2_out_q;
    logic [DCC_W-1:0]  dcc_out_q;
    logic              we_out_q;
    logic [REG_AW-1:0] rd_out_q;

    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res;
    logic [4:0]        shamt;

    always_comb begin
        aluop_d = bus.flush ? '0 : bus.ALUop;
        dcc_d   = bus.flush ? '0 : bus.dataCacheControlIn;
        we_d    = bus.flush ? 1'b0 : bus.writeEnableReg;
    end

    // Select 3 is unused by the forwarding unit and falls back to the register value.
    always_comb begin
        case (bus.select1)
            2'd1:    op_a = data_out_q;
            2'd2:    op_a = bus.regDataFromMEM_WB;
            default: op_a = rs1_q;
        endcase
        case (bus.select2)
            2'd1:    fwd_b = data_out_q;
            2'd2:    fwd_b = bus.regDataFromMEM_WB;
            default: fwd_b = rs2_q;
        endcase
        op_b  = aluop_q[4] ? imm_q : fwd_b;
        shamt = op_b[4:0];
    end

    always_comb begin
        alu_res = '0;
        case (aluop_q[3:0])
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd4:    alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            rd_q       <= '0;
            aluop_q    <= '0;
            dcc_q      <= '0;
            we_q       <= 1'b0;
            data_out_q <= '0;
            rs2_out_q  <= '0;
            dcc_out_q  <= '0;
            we_out_q   <= 1'b0;
            rd_out_q   <= '0;
        end else begin
            rs1_q      <= bus.dataReg1;
            rs2_q      <= bus.dataReg2;
            imm_q      <= bus.immValueIn;
            s1_addr_q  <= bus.dataS1AddrIn;
            s2_addr_q  <= bus.dataS2AddrIn;
            rd_q       <= bus.writeBackAddrIn;
            aluop_q    <= aluop_d;
            dcc_q      <= dcc_d;
            we_q       <= we_d;
            // Store data takes the forwarded rs2, not the stale register-file copy.
            data_out_q <= alu_res;
            rs2_out_q  <= fwd_b;
            dcc_out_q  <= dcc_q;
            we_out_q   <= we_q;
            rd_out_q   <= rd_q;
        end
    end

    assign bus.dataS1AddrOut       = s1_addr_q;
    assign bus.dataS2AddrOut       = s2_addr_q;
    assign bus.aluResult           = alu_res;
    assign bus.dataOut             = data_out_q;
    assign bus.dataRs2Out          = rs2_out_q;
    assign bus.dataCacheControlOut = dcc_out_q;
    assign bus.writeEnableOut      = we_out_q;
    assign bus.writeBackAddrOut    = rd_out_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: issued vectors push expected EX/MEM contents,
// a monitor pops and compares when the issued slot reaches EX/MEM.
module tb_execute_stage;
    localparam int EXP_W = 74;
    localparam int NVEC  = 17;

    logic clk;
    logic resetIn;
    logic issue;
    logic vld_dec, vld_mem;
    int   n_tests, n_fail, mon_idx;
    logic [EXP_W-1:0] exp_q[$];

    typedef struct {
        logic [31:0] r1, r2, imm, wb, e_data, e_rs2;
        logic [4:0]  op, rd, e_rd;
        logic [2:0]  dcc, e_dcc;
        logic        we, fl, e_we;
        logic [1:0]  s1, s2;
    } vec_t;

    vec_t vecs[NVEC];

    execute_stage_if #(.DATA_W(32), .REG_AW(5), .OP_W(5), .DCC_W(3)) bus ();

    execute_stage #(.DATA_W(32), .REG_AW(5), .OP_W(5), .DCC_W(3)) dut (
        .clk     (clk),
        .resetIn (resetIn),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [31:0] r1, logic [31:0] r2, logic [31:0] imm,
                                logic [4:0] op, logic [4:0] rd, logic [2:0] dcc,
                                logic we, logic fl, logic [1:0] s1, logic [1:0] s2,
                                logic [31:0] wb, logic [31:0] e_data, logic [31:0] e_rs2);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.imm = imm; v.op = op; v.rd = rd; v.dcc = dcc;
        v.we = we; v.fl = fl; v.s1 = s1; v.s2 = s2; v.wb = wb;
        v.e_data = e_data; v.e_rs2 = e_rs2;
        v.e_dcc = fl ? 3'd0 : dcc;
        v.e_we  = fl ? 1'b0 : we;
        v.e_rd  = rd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, required 0x%08h", name, idx, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle_dec();
        bus.flush = 1'b0; bus.dataReg1 = '0; bus.dataReg2 = '0;
        bus.dataS1AddrIn = '0; bus.dataS2AddrIn = '0; bus.writeBackAddrIn = '0;
        bus.ALUop = '0; bus.immValueIn = '0; bus.dataCacheControlIn = '0;
        bus.writeEnableReg = 1'b0; issue = 1'b0;
    endtask

    task automatic drive_idle_ex();
        bus.select1 = 2'd0; bus.select2 = 2'd0; bus.regDataFromMEM_WB = '0;
    endtask

    task automatic drive_dec(input vec_t v, input int k);
        bus.flush = v.fl; bus.dataReg1 = v.r1; bus.dataReg2 = v.r2;
        bus.dataS1AddrIn = 5'(k + 1); bus.dataS2AddrIn = 5'(k + 2);
        bus.writeBackAddrIn = v.rd; bus.ALUop = v.op; bus.immValueIn = v.imm;
        bus.dataCacheControlIn = v.dcc; bus.writeEnableReg = v.we;
    endtask

    task automatic drive_ex(input vec_t v);
        bus.select1 = v.s1; bus.select2 = v.s2; bus.regDataFromMEM_WB = v.wb;
    endtask

    // Bench-side slot tracker: an issued slot reaches EX/MEM two edges later.
    always @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            vld_dec <= 1'b0;
            vld_mem <= 1'b0;
        end else begin
            vld_dec <= issue;
            vld_mem <= vld_dec;
        end
    end

    // scoreboard monitor
    always @(posedge clk) begin
        logic [EXP_W-1:0] e;
        #1;
        if (vld_mem) begin
            if (exp_q.size() == 0) begin
                check("exp_q underflow", mon_idx, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e[0]) begin
                    check("dataOut", mon_idx, bus.dataOut, e[73:42]);
                    check("dataRs2Out", mon_idx, bus.dataRs2Out, e[41:10]);
                    check("writeBackAddrOut", mon_idx, 32'(bus.writeBackAddrOut), 32'(e[5:1]));
                end
                check("dataCacheControlOut", mon_idx, 32'(bus.dataCacheControlOut), 32'(e[9:7]));
                check("writeEnableOut", mon_idx, 32'(bus.writeEnableOut), 32'(e[6]));
            end
            mon_idx++;
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; mon_idx = 0;
        //            r1            r2            imm           op        rd  dcc we fl s1 s2 wb            e_data        e_rs2
        vecs[0]  = mk(32'd5,        32'd0,        32'd7,        5'b10000, 17, 0, 1, 0, 0, 0, 32'd0,        32'd12,       32'd0);
        vecs[1]  = mk(32'd3,        32'd4,        32'd0,        5'b00000, 1,  0, 1, 0, 0, 0, 32'd0,        32'd7,        32'd4);
        vecs[2]  = mk(32'd99,       32'd1,        32'd0,        5'b00001, 2,  0, 1, 0, 1, 0, 32'd0,        32'd6,        32'd1);
        vecs[3]  = mk(32'h100,      32'h1111,     32'd8,        5'b10000, 0,  2, 0, 0, 0, 2, 32'hDEADBEEF, 32'h108,      32'hDEADBEEF);
        vecs[4]  = mk(32'h80000000, 32'd4,        32'd0,        5'd7,     3,  0, 1, 0, 0, 0, 32'd0,        32'hF8000000, 32'd4);
        vecs[5]  = mk(32'h80000000, 32'd4,        32'd0,        5'd6,     4,  0, 1, 0, 0, 0, 32'd0,        32'h08000000, 32'd4);
        vecs[6]  = mk(32'h80000000, 32'd4,        32'd1,        5'b10011, 5,  0, 1, 0, 0, 0, 32'd0,        32'd1,        32'd4);
        vecs[7]  = mk(32'h80000000, 32'd4,        32'd1,        5'b10100, 6,  0, 1, 0, 0, 0, 32'd0,        32'd0,        32'd4);
        vecs[8]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd5,     7,  0, 1, 0, 0, 0, 32'd0,        32'h0FF00FF0, 32'hFF00FF00);
        vecs[9]  = mk(32'd1,        32'h23,       32'd0,        5'd2,     8,  0, 1, 0, 0, 0, 32'd0,        32'd8,        32'h23);
        vecs[10] = mk(32'hFFFF,     32'd9,        32'h12345000, 5'b11010, 9,  0, 1, 0, 0, 0, 32'd0,        32'h12345000, 32'd9);
        vecs[11] = mk(32'd10,       32'd20,       32'd0,        5'd1,     10, 0, 1, 0, 3, 3, 32'hAAAA,     32'hFFFFFFF6, 32'd20);
        vecs[12] = mk(32'd5,        32'd6,        32'd0,        5'b01011, 11, 0, 1, 0, 0, 0, 32'd0,        32'd0,        32'd6);
        vecs[13] = mk(32'hFF00FF00, 32'h0FF00FF0, 32'd0,        5'd9,     12, 0, 1, 0, 0, 0, 32'd0,        32'h0F000F00, 32'h0FF00FF0);
        vecs[14] = mk(32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,     13, 0, 1, 0, 0, 0, 32'd0,        32'd0,        32'd1);
        vecs[15] = mk(32'h200,      32'h55,       32'd4,        5'b10000, 14, 2, 1, 1, 0, 0, 32'd0,        32'd0,        32'd0);
        vecs[16] = mk(32'd1,        32'd1,        32'd0,        5'd0,     15, 0, 1, 0, 0, 0, 32'd0,        32'd2,        32'd1);

        // Reset held while clocking live-looking inputs.
        resetIn = 1'b0;
        drive_dec(vecs[0], 0);
        issue = 1'b0;
        drive_ex(vecs[3]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst dataS1AddrOut", 0, 32'(bus.dataS1AddrOut), 32'd0);
        check("rst dataS2AddrOut", 0, 32'(bus.dataS2AddrOut), 32'd0);
        check("rst dataOut", 0, bus.dataOut, 32'd0);
        check("rst dataRs2Out", 0, bus.dataRs2Out, 32'd0);
        check("rst dataCacheControlOut", 0, 32'(bus.dataCacheControlOut), 32'd0);
        check("rst writeEnableOut", 0, 32'(bus.writeEnableOut), 32'd0);
        check("rst writeBackAddrOut", 0, 32'(bus.writeBackAddrOut), 32'd0);

        drive_idle_dec();
        drive_idle_ex();
        resetIn = 1'b1;
        @(posedge clk);
        #1;
        check("post-rst dataOut", 0, bus.dataOut, 32'd0);
        check("post-rst writeEnableOut", 0, 32'(bus.writeEnableOut), 32'd0);

        // Main stream: decode fields of vector k, EX-time selects of vector k-1.
        for (int k = 0; k <= NVEC; k++) begin
            @(negedge clk);
            if (k < NVEC) begin
                drive_dec(vecs[k], k);
                issue = 1'b1;
                exp_q.push_back({vecs[k].e_data, vecs[k].e_rs2, vecs[k].e_dcc,
                                 vecs[k].e_we, vecs[k].e_rd, ~vecs[k].fl});
            end else begin
                drive_idle_dec();
            end
            if (k > 0) drive_ex(vecs[k-1]);
            else       drive_idle_ex();
        end
        @(negedge clk);
        drive_idle_ex();
        repeat (3) @(negedge clk);
        check("exp_q drained", 0, 32'(exp_q.size()), 32'd0);

        // Asynchronous reset between edges.
        @(negedge clk);
        drive_dec(mk(32'd3, 32'd4, 32'd0, 5'd0, 9, 1, 1, 0, 0, 0, 32'd0, 32'd0, 32'd0), 2);
        @(negedge clk);
        drive_idle_dec();
        drive_idle_ex();
        #1;
        check("aluResult comb", 0, bus.aluResult, 32'd7);
        check("dataS1AddrOut", 0, 32'(bus.dataS1AddrOut), 32'd3);
        check("dataS2AddrOut", 0, 32'(bus.dataS2AddrOut), 32'd4);
        @(posedge clk);
        #3;
        check("pre-async dataOut", 0, bus.dataOut, 32'd7);
        check("pre-async writeEnableOut", 0, 32'(bus.writeEnableOut), 32'd1);
        resetIn = 1'b0;
        #1;
        check("async dataOut", 0, bus.dataOut, 32'd0);
        check("async dataRs2Out", 0, bus.dataRs2Out, 32'd0);
        check("async dataCacheControlOut", 0, 32'(bus.dataCacheControlOut), 32'd0);
        check("async writeEnableOut", 0, 32'(bus.writeEnableOut), 32'd0);
        check("async writeBackAddrOut", 0, 32'(bus.writeBackAddrOut), 32'd0);
        @(negedge clk);
        resetIn = 1'b1;
        repeat (2) @(negedge clk);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
